// File: rtl/pattern_video_src.sv
// pattern_video_src: free-running video timing generator with selectable test patterns
// Ports:
//   clk          rising-edge clock
//   reset_1      synchronous active-low reset
//   en           run request; dropping it lets the current frame finish
//   src_sel      pattern select (0 h-ramp, 1 v-ramp, 2 checkerboard, 3 moving diagonal)
//   test_data    pixel data, zero outside the active region
//   test_dvalid  active-pixel qualifier
//   test_vsync   vertical sync
//   test_hsync   horizontal sync
//   sof          one-clock pulse with the first active pixel of a frame
//   frame_cnt    completed-frame count
module pattern_video_src #(
  parameter int IW      = 640,
  parameter int IH      = 512,
  parameter int DW      = 8,
  parameter int H_TOTAL = 1440,
  parameter int V_TOTAL = 600,
  parameter int SYNC_B  = 5,
  parameter int SYNC_E  = 55,
  parameter int VLD_B   = 65,
  parameter int H_VLD_B = 400,
  parameter int HS_W    = 40
) (
  input  logic          clk,
  input  logic          reset_1,
  input  logic          en,
  input  logic [1:0]    src_sel,
  output logic [DW-1:0] test_data,
  output logic          test_dvalid,
  output logic          test_vsync,
  output logic          test_hsync,
  output logic          sof,
  output logic [15:0]   frame_cnt
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0]    state_q, state_d, sel_q, sel_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [15:0]   fc_q, fc_d;
  logic [DW-1:0] data_q, data_d, pix;
  logic          dv_q, dv_d, vs_q, vs_d, hs_q, hs_d, sof_q, sof_d;
  logic          run, h_end, f_end;
  int            x, y;
  assign run   = state_q != IDLE;
  assign h_end = h_q == HW'(H_TOTAL - 1);
  assign f_end = h_end && v_q == VW'(V_TOTAL - 1);
  always_comb begin
    state_d = state_q == IDLE ? (en ? RUN : IDLE) :
              en ? RUN : state_q == RUN ? DRAIN : f_end ? IDLE : DRAIN;
    h_d     = !run || h_end ? '0 : h_q + 1'b1;
    v_d     = !run || f_end ? '0 : h_end ? v_q + 1'b1 : v_q;
    fc_d    = run && f_end ? fc_q + 16'd1 : fc_q;
    // pattern only changes at a frame boundary so a frame is never mixed
    sel_d   = (state_q == IDLE && en) || (state_q == RUN && h_q == '0 && v_q == '0) ? src_sel : sel_q;
    x       = int'(h_q) - H_VLD_B;
    y       = int'(v_q) - VLD_B;
    dv_d    = run && x >= 0 && x < IW && y >= 0 && y < IH;
    pix     = sel_q == 2'd0 ? DW'(x) :
              sel_q == 2'd1 ? DW'(y) :
              sel_q == 2'd2 ? {DW{x[3] ^ y[3]}} : DW'(x + y + int'(fc_q));
    data_d  = dv_d ? pix : '0;
    vs_d    = run && int'(v_q) >= SYNC_B && int'(v_q) < SYNC_E;
    hs_d    = run && int'(h_q) < HS_W;
    sof_d   = dv_d && x == 0 && y == 0;
  end
  always_ff @(posedge clk) begin
    if (!reset_1) begin
      state_q <= IDLE;
      sel_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      fc_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fc_q    <= fc_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      sof_q   <= sof_d;
    end
  end
  assign test_data   = data_q;
  assign test_dvalid = dv_q;
  assign test_vsync  = vs_q;
  assign test_hsync  = hs_q;
  assign sof         = sof_q;
  assign frame_cnt   = fc_q;
endmodule

// File: tb/tb_pattern_video_src.sv
// tb_pattern_video_src: directed checks of timing, patterns, FSM and reset
module tb_pattern_video_src;
  logic        clk = 1'b0;
  logic        rst0_n, en0, rst1_n, en1;
  logic [1:0]  sel0, sel1;
  logic [7:0]  data0;
  logic [3:0]  data1;
  logic        dv0, vs0, hs0, sof0, dv1, vs1, hs1, sof1;
  logic [15:0] fc0, fc1;
  int          n_chk = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  pattern_video_src #(.IW(4), .IH(2), .DW(8), .H_TOTAL(8), .V_TOTAL(6), .SYNC_B(0),
                      .SYNC_E(1), .VLD_B(2), .H_VLD_B(3), .HS_W(2)) u0 (
    .clk(clk), .reset_1(rst0_n), .en(en0), .src_sel(sel0), .test_data(data0),
    .test_dvalid(dv0), .test_vsync(vs0), .test_hsync(hs0), .sof(sof0), .frame_cnt(fc0));
  pattern_video_src #(.IW(20), .IH(1), .DW(4), .H_TOTAL(24), .V_TOTAL(4), .SYNC_B(0),
                      .SYNC_E(1), .VLD_B(2), .H_VLD_B(3), .HS_W(2)) u1 (
    .clk(clk), .reset_1(rst1_n), .en(en1), .src_sel(sel1), .test_data(data1),
    .test_dvalid(dv1), .test_vsync(vs1), .test_hsync(hs1), .sof(sof1), .frame_cnt(fc1));
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  function automatic logic [11:0] exp0(input int n, input logic [1:0] ps, input logic [15:0] fc);
    int h = n % 8;
    int v = n / 8;
    int x = h - 3;
    int y = v - 2;
    logic dv = x >= 0 && x < 4 && y >= 0 && y < 2;
    logic [7:0] d = ps == 2'd0 ? 8'(x) : ps == 2'd1 ? 8'(y) :
                    ps == 2'd2 ? ((x[3] ^ y[3]) ? 8'hff : 8'h00) : 8'(x + y + int'(fc));
    return {dv && x == 0 && y == 0, dv, v == 0, h < 2, dv ? d : 8'h00};
  endfunction
  function automatic logic [7:0] exp1(input int n, input logic [1:0] ps);
    int h = n % 24;
    int v = n / 24;
    int x = h - 3;
    int y = v - 2;
    logic dv = x >= 0 && x < 20 && y == 0;
    logic [3:0] d = ps == 2'd0 ? 4'(x) : ((x[3] ^ y[3]) ? 4'hf : 4'h0);
    return {dv && x == 0, dv, v == 0, h < 2, dv ? d : 4'h0};
  endfunction
  task automatic run_frame(input string nm, input logic [1:0] ps, input logic [15:0] fc,
                           input int sel_n, input logic [1:0] sel_v, input int off_n, input int on_n);
    for (int n = 0; n < 48; n++) begin
      step(1);
      check($sformatf("%s_n%0d", nm, n), 32'({sof0, dv0, vs0, hs0, data0}), 32'(exp0(n, ps, fc)));
      if (n == sel_n) sel0 = sel_v;
      if (n == off_n) en0 = 1'b0;
      if (n == on_n) en0 = 1'b1;
    end
  endtask
  task automatic run_u1(input string nm, input logic [1:0] ps);
    for (int n = 0; n < 96; n++) begin
      step(1);
      check($sformatf("%s_n%0d", nm, n), 32'({sof1, dv1, vs1, hs1, data1}), 32'(exp1(n, ps)));
    end
  endtask
  initial begin
    rst0_n = 1'b0; en0 = 1'b0; sel0 = 2'd0;
    rst1_n = 1'b0; en1 = 1'b0; sel1 = 2'd0;
    step(2);
    check("rst_out", 32'({sof0, dv0, vs0, hs0, data0}), 32'd0);
    check("rst_fc", 32'(fc0), 32'd0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    step(3);
    check("idle_out", 32'({sof0, dv0, vs0, hs0, data0}), 32'd0);
    en0 = 1'b1;
    step(1);
    run_frame("f0", 2'd0, 16'd0, -1, 2'd0, -1, -1);
    check("fc_f0", 32'(fc0), 32'd1);
    sel0 = 2'd3;
    run_frame("f1", 2'd3, 16'd1, -1, 2'd0, -1, -1);
    run_frame("f2", 2'd3, 16'd2, 47, 2'd0, -1, -1);
    run_frame("f3", 2'd0, 16'd3, 20, 2'd1, -1, -1);
    run_frame("f4", 2'd1, 16'd4, -1, 2'd0, -1, -1);
    run_frame("f5", 2'd1, 16'd5, -1, 2'd0, 10, -1);
    check("fc_drain", 32'(fc0), 32'd6);
    step(3);
    check("drain_idle_out", 32'({sof0, dv0, vs0, hs0, data0}), 32'd0);
    check("drain_idle_fc", 32'(fc0), 32'd6);
    en0 = 1'b1;
    step(1);
    run_frame("f6", 2'd1, 16'd6, -1, 2'd0, 10, 30);
    run_frame("f7", 2'd1, 16'd7, -1, 2'd0, -1, -1);
    check("fc_f7", 32'(fc0), 32'd8);
    step(21);
    check("mid_line", 32'({sof0, dv0, vs0, hs0, data0}), 32'(exp0(20, 2'd1, 16'd8)));
    rst0_n = 1'b0; en0 = 1'b0; sel0 = 2'd3;
    step(1);
    check("mid_rst_out", 32'({sof0, dv0, vs0, hs0, data0}), 32'd0);
    check("mid_rst_fc", 32'(fc0), 32'd0);
    rst0_n = 1'b1;
    step(3);
    check("post_rst_quiet", 32'({sof0, dv0, vs0, hs0, data0}), 32'd0);
    en0 = 1'b1;
    step(1);
    run_frame("f9", 2'd3, 16'd0, -1, 2'd0, -1, -1);
    check("fc_restart", 32'(fc0), 32'd1);
    force u1.fc_q = 16'hffff;
    step(1);
    release u1.fc_q;
    check("fc1_preset", 32'(fc1), 32'h0000ffff);
    en1 = 1'b1;
    step(1);
    run_u1("w0", 2'd0);
    check("fc1_wrap", 32'(fc1), 32'd0);
    sel1 = 2'd2;
    run_u1("w1", 2'd2);
    check("fc1_after", 32'(fc1), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
